// File: rtl/xor_cipher_bist_if.sv
// Serial config and cipher data loop between the BIST engine and the
// TX/RX XOR cipher pair under test.
interface xor_cipher_bist_if;
  logic cfg_i;
  logic cfg_o;
  logic cfg_en;
  logic en;
  logic datastream;
  logic decrypted;

  modport master (
    output cfg_o, cfg_en, en, datastream,
    input  cfg_i, decrypted
  );

  modport slave (
    input  cfg_o, cfg_en, en, datastream,
    output cfg_i, decrypted
  );
endinterface

// File: rtl/xor_cipher_bist.sv
// Self-test engine for the dual XOR cipher loop: config shift, PRBS run,
// latency-aligned compare. Optional inject port via XOR_BIST_INJECT_EN.
module xor_cipher_bist #(
  parameter int M          = 32,
  parameter int RUN_CYCLES = 900,
  parameter int LAT        = 2,
  parameter int ERR_W      = 16,
  parameter int CNT_W      = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             continuous,
  input  logic [1:0]       prbs_sel,
  input  logic             mux_ext_a,
  input  logic             mux_en_d,
  input  logic [M-1:0]     tx_taps,
  input  logic [M-1:0]     tx_state,
  input  logic [M-1:0]     rx_taps,
  input  logic [M-1:0]     rx_state,
`ifdef XOR_BIST_INJECT_EN
  input  logic             inject,
`endif
  xor_cipher_bist_if.master cif,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] error_count,
  output logic [ERR_W-1:0] bit_count
);

  localparam int CFG_LEN = 4*M + 2;

  localparam logic [CNT_W-1:0] CFG_LAST =
    CNT_W'(CFG_LEN - 1);
  localparam logic [CNT_W-1:0] RUN_LAST =
    CNT_W'(RUN_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST =
    CNT_W'((LAT > 0) ? LAT - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CFG,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [CNT_W-1:0]   cnt;
  logic [CFG_LEN-1:0] cfg_reg;
  logic [30:0]        lfsr;
  logic [1:0]         sel;

  logic prbs_bit;
  logic fb;
  logic run;
  logic restart;
  logic src;
  logic cmp_dat;
  logic cmp_en;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // next state
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (start) state_nx = S_LOAD;
      S_LOAD:  state_nx = S_CFG;
      S_CFG:   if (cnt == CFG_LAST) state_nx = S_RUN;
      S_RUN: begin
        if (stop || (!continuous && cnt >= RUN_LAST))
          state_nx = (LAT == 0) ? S_DONE : S_DRAIN;
      end
      S_DRAIN: if (cnt == DRAIN_LAST) state_nx = S_DONE;
      S_DONE:  state_nx = continuous ? S_LOAD : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // outputs
  always_comb begin
    cif.cfg_en = 1'b0;
    run        = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    unique case (state)
      S_IDLE:  busy = 1'b0;
      S_CFG:   cif.cfg_en = 1'b1;
      S_RUN:   run = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign cif.en    = run;
  assign cif.cfg_o = cfg_reg[0];

  assign restart = (state == S_IDLE && start) ||
                   (state == S_DONE && continuous);

  always_comb begin
    fb       = 1'b0;
    prbs_bit = 1'b0;
    unique case (sel)
      2'b00: begin
        prbs_bit = lfsr[6];
        fb       = lfsr[6] ^ lfsr[5];
      end
      2'b01: begin
        prbs_bit = lfsr[14];
        fb       = lfsr[14] ^ lfsr[13];
      end
      2'b10: begin
        prbs_bit = lfsr[22];
        fb       = lfsr[22] ^ lfsr[17];
      end
      default: begin
        prbs_bit = lfsr[30];
        fb       = lfsr[30] ^ lfsr[27];
      end
    endcase
  end

  // the compare pipe always sees the raw PRBS bit
  assign src = run & prbs_bit;

`ifdef XOR_BIST_INJECT_EN
  assign cif.datastream = run & (prbs_bit ^ inject);
`else
  assign cif.datastream = src;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (state_nx != state)
      cnt <= '0;
    else if (state != S_IDLE)
      cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sel <= 2'b00;
    else if (state == S_IDLE && start)
      sel <= prbs_sel;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      lfsr <= '0;
    else if (restart)
      lfsr <= 31'd1;
    else if (run)
      lfsr <= {lfsr[29:0], fb};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cfg_reg <= '0;
    else if (state == S_LOAD)
      cfg_reg <= {mux_ext_a, mux_en_d,
                  tx_taps, tx_state,
                  rx_taps, rx_state};
    else if (state == S_CFG)
      cfg_reg <= {cif.cfg_i, cfg_reg[CFG_LEN-1:1]};
  end

  generate
    if (LAT > 0) begin : g_pipe
      logic [LAT-1:0] pd;
      logic [LAT-1:0] pe;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          pd <= '0;
          pe <= '0;
        end else begin
          pd[0] <= src;
          pe[0] <= run;
          for (int i = 1; i < LAT; i++) begin
            pd[i] <= pd[i-1];
            pe[i] <= pe[i-1];
          end
        end
      end

      assign cmp_dat = pd[LAT-1];
      assign cmp_en  = pe[LAT-1];
    end else begin : g_nopipe
      assign cmp_dat = src;
      assign cmp_en  = run;
    end
  endgenerate

  // saturating counters, cleared at the start of every pass
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      error_count <= '0;
      bit_count   <= '0;
    end else if (restart) begin
      error_count <= '0;
      bit_count   <= '0;
    end else if (cmp_en) begin
      if (bit_count != '1)
        bit_count <= bit_count + 1'b1;
      if (cmp_dat != cif.decrypted &&
          error_count != '1)
        error_count <= error_count + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pass <= 1'b0;
    else if (state == S_IDLE && start)
      pass <= 1'b0;
    else if (state == S_DONE)
      pass <= (error_count == '0) &&
              (bit_count != '0);
  end

endmodule

// File: tb/tb_xor_cipher_bist.sv
// Bench for xor_cipher_bist: loop-back cipher model, scoreboard of
// per-pass results, plus a small saturating LAT=0 instance.
module tb_xor_cipher_bist;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        continuous = 1'b0;
  logic [1:0]  prbs_sel = 2'b00;
  logic        mux_ext_a = 1'b0;
  logic        mux_en_d = 1'b0;
  logic [31:0] tx_taps = '0;
  logic [31:0] tx_state = '0;
  logic [31:0] rx_taps = '0;
  logic [31:0] rx_state = '0;
  logic        busy, done, pass;
  logic [15:0] err_cnt, bit_cnt;
`ifdef XOR_BIST_INJECT_EN
  logic        inject = 1'b0;
`endif

  xor_cipher_bist_if cif ();
  assign cif.cfg_i = cif.cfg_o;

  xor_cipher_bist dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .continuous(continuous), .prbs_sel(prbs_sel),
    .mux_ext_a(mux_ext_a), .mux_en_d(mux_en_d),
    .tx_taps(tx_taps), .tx_state(tx_state),
    .rx_taps(rx_taps), .rx_state(rx_state),
`ifdef XOR_BIST_INJECT_EN
    .inject(inject),
`endif
    .cif(cif), .busy(busy), .done(done), .pass(pass),
    .error_count(err_cnt), .bit_count(bit_cnt)
  );

  // small instance: M=8, 40 run cycles, no latency, 4-bit counters
  logic       start2 = 1'b0;
  logic       flip2 = 1'b0;
  logic [7:0] z8 = '0;
  logic       busy2, done2, pass2;
  logic [3:0] err2, bit2;
  xor_cipher_bist_if cif2 ();
  assign cif2.cfg_i = cif2.cfg_o;
  assign cif2.decrypted = cif2.datastream ^ flip2;

  xor_cipher_bist #(
    .M(8), .RUN_CYCLES(40), .LAT(0), .ERR_W(4), .CNT_W(12)
  ) dut2 (
    .clk(clk), .rst(rst), .start(start2), .stop(1'b0),
    .continuous(1'b0), .prbs_sel(2'b00),
    .mux_ext_a(1'b0), .mux_en_d(1'b0),
    .tx_taps(z8), .tx_state(z8),
    .rx_taps(z8), .rx_state(z8),
`ifdef XOR_BIST_INJECT_EN
    .inject(1'b0),
`endif
    .cif(cif2), .busy(busy2), .done(done2), .pass(pass2),
    .error_count(err2), .bit_count(bit2)
  );

  // loop-back cipher: decrypted = datastream delayed 2, optional flips
  logic d1 = 1'b0, d2 = 1'b0;
  int   en_idx = 0;
  bit   flip_on = 1'b0;
  int   flip_list [5] = '{0, 1, 100, 500, 899};

  function automatic bit hit(input int k);
    for (int i = 0; i < 5; i++)
      if (flip_list[i] == k) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    if (start) en_idx <= 0;
    else if (cif.en) en_idx <= en_idx + 1;
    d1 <= cif.datastream ^ (cif.en & flip_on & hit(en_idx));
    d2 <= d1;
  end
  assign cif.decrypted = d2;

  int nvec = 0;
  int nmis = 0;

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    int           cfg_n;
    int           en_n;
    int           err;
    int           bits;
    bit           pass;
    logic [129:0] word;
  } exp_t;

  exp_t sb [$];

  // monitor: per-pass measurements, compared on each done pulse
  int           mc = 0, me = 0;
  logic [129:0] cap_w = '0;
  bit           prev_done = 1'b0, pend = 1'b0, exp_pass = 1'b0;
  exp_t         e;

  always @(negedge clk) begin
    if (rst) begin
      mc = 0; me = 0; prev_done = 1'b0; pend = 1'b0;
    end else begin
      if (pend) begin
        chk("pass", pass, exp_pass);
        pend = 1'b0;
      end
      if (cif.cfg_en) begin
        if (mc < 130) cap_w[mc] = cif.cfg_o;
        mc++;
      end
      if (cif.en) me++;
      if (done) begin
        chk("done_width", prev_done, 0);
        chk("sb_has_entry", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("cfg_cycles", mc, e.cfg_n);
          chk("en_cycles", me, e.en_n);
          chk("error_count", err_cnt, e.err);
          chk("bit_count", bit_cnt, e.bits);
          chk("cfg_word", cap_w == e.word, 1);
          exp_pass = e.pass;
          pend = 1'b1;
        end
        mc = 0; me = 0;
      end
      prev_done = done;
    end
  end

  logic ds_cap [1024];
  int   cap_n = 0;
  always @(negedge clk) begin
    if (start) cap_n = 0;
    else if (cif.en && cap_n < 1024) begin
      ds_cap[cap_n] = cif.datastream;
      cap_n++;
    end
  end

  function automatic int first_one();
    for (int i = 0; i < 1024; i++)
      if (ds_cap[i]) return i;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done) break;
    end
    chk(nm, k < budget, 1);
  endtask

  task automatic wait_en_idx(input string nm, input int n);
    int k;
    for (k = 0; k < 3000; k++) begin
      if (cif.en && en_idx == n) break;
      tick();
    end
    chk(nm, k < 3000, 1);
  endtask

  task automatic run2(input bit f, input int e_err,
                      input int e_pass);
    int k;
    flip2 = f;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done2) break;
    end
    chk("s2_done", k < 200, 1);
    chk("s2_error_count", err2, e_err);
    chk("s2_bit_count", bit2, 15);
    @(negedge clk);
    chk("s2_pass", pass2, e_pass);
    tick();
  endtask

  logic [129:0] word;
  int           ones, bad, rep;
  logic [30:0]  w0, wj;

  initial begin
    word = {2'b00, 32'hA5A5_0001, 96'b0};
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cfg_en", cif.cfg_en, 0);
    chk("rst_en", cif.en, 0);
    chk("rst_datastream", cif.datastream, 0);
    chk("rst_cfg_o", cif.cfg_o, 0);
    chk("rst_error_count", err_cnt, 0);
    chk("rst_bit_count", bit_cnt, 0);
    chk("rst_pass", pass, 0);
    rst = 1'b0;
    tick();

    // clean PRBS-7 pass
    tx_taps = 32'hA5A5_0001;
    prbs_sel = 2'b00;
    sb.push_back('{130, 900, 0, 900, 1'b1, word});
    pulse_start();
    wait_done("A_done", 1500);
    tick();
    tick();
    chk("A_hold_bits", bit_cnt, 900);
    chk("A_hold_busy", busy, 0);
    ones = 0;
    bad = 0;
    for (int i = 0; i < 127; i++) begin
      ones += int'(ds_cap[i]);
      if (ds_cap[i] != ds_cap[i+127]) bad++;
    end
    chk("prbs7_ones", ones, 64);
    chk("prbs7_period", bad, 0);
    chk("prbs7_first_one", first_one(), 6);

    // PRBS-31 with 5 flipped bits
    flip_on = 1'b1;
    prbs_sel = 2'b11;
    sb.push_back('{130, 900, 5, 900, 1'b0, word});
    pulse_start();
    wait_done("B_done", 1500);
    tick();
    tick();
    flip_on = 1'b0;
    chk("prbs31_first_one", first_one(), 30);
    for (int i = 0; i < 31; i++) w0[i] = ds_cap[i];
    rep = 0;
    for (int j = 1; j + 31 <= 900; j++) begin
      for (int i = 0; i < 31; i++) wj[i] = ds_cap[j+i];
      if (wj == w0) rep++;
    end
    chk("prbs31_no_repeat", rep, 0);

    // continuous with stop after 300 run cycles, then auto-restart
    continuous = 1'b1;
    prbs_sel = 2'b01;
    sb.push_back('{130, 300, 0, 300, 1'b1, word});
    pulse_start();
    wait_en_idx("C_reach_300", 299);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_done("C_done", 50);
    sb.push_back('{130, 900, 0, 900, 1'b1, word});
    @(negedge clk);
    chk("C_load_busy", busy, 1);
    chk("C_load_cfg_en", cif.cfg_en, 0);
    @(negedge clk);
    chk("C_cfg_en", cif.cfg_en, 1);
    #1;
    continuous = 1'b0;
    wait_done("C2_done", 1500);
    tick();
    tick();

    // reset in the middle of config shifting
    pulse_start();
    repeat (12) tick();
    chk("D_in_cfg", cif.cfg_en, 1);
    rst = 1'b1;
    #1;
    chk("D_rst_busy", busy, 0);
    chk("D_rst_cfg_en", cif.cfg_en, 0);
    chk("D_rst_cfg_o", cif.cfg_o, 0);
    chk("D_rst_en", cif.en, 0);
    chk("D_rst_bits", bit_cnt, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("D_idle", busy, 0);

    // saturation on the small instance
    run2(1'b1, 15, 0);
    run2(1'b0, 0, 1);

`ifdef XOR_BIST_INJECT_EN
    prbs_sel = 2'b00;
    sb.push_back('{130, 50, 3, 50, 1'b0, word});
    pulse_start();
    wait_en_idx("F_reach_10", 10);
    inject = 1'b1;
    repeat (3) tick();
    inject = 1'b0;
    wait_en_idx("F_reach_50", 49);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_done("F_done", 50);
    tick();
    tick();
`endif

    chk("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nmis);
    $finish;
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
